// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared pipeline package: register index width, hazard FSM states,
// priority-winner encoding and the canonical nop instruction word.
package pipe_hazard_ctrl_pkg;

   localparam int REG_W  = 5;
   // Wide enough for a FLUSH countdown of FLUSH_LAT-1 with FLUSH_LAT up to 3.
   localparam int FCNT_W = 2;

   // addi x0, x0, 0 -- the bubble fetch substitutes into IF/ID.
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic {
      RUN   = 1'b0,
      FLUSH = 1'b1
   } state_e;

   // Which priority level owns the current cycle, highest first.
   typedef enum logic [2:0] {
      SEL_FREEZE = 3'd0,  // data memory busy: freeze everything
      SEL_EX_BR  = 3'd1,  // late branch/jump redirect from EX
      SEL_FLUSH  = 3'd2,  // wrong-path nop cycles after a redirect
      SEL_HAZARD = 3'd3,  // load-use or early-branch operand dependency
      SEL_ID_BR  = 3'd4,  // early branch redirect from ID
      SEL_IWAIT  = 3'd5,  // instruction memory not ready
      SEL_IDLE   = 3'd6   // normal flow
   } sel_e;

endpackage

// File: rtl/pipe_hazard_detect.sv
// Purely combinational hazard compare: load-use stall and early-branch
// operand dependency for the instruction sitting in ID.
module pipe_hazard_detect #(
   parameter int REG_W = pipe_hazard_ctrl_pkg::REG_W
) (
   input  logic [REG_W-1:0] id_rs1,
   input  logic [REG_W-1:0] id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             id_is_branch,
   input  logic [REG_W-1:0] ex_rd,
   input  logic             ex_wen,
   input  logic             ex_is_load,
   input  logic [REG_W-1:0] mem_rd,
   input  logic             mem_is_load,
   output logic             luse,
   output logic             bdep
);

   // True when r is a live source of the ID instruction; x0 is hardwired
   // zero, so a compare on index 0 never matches.
   function automatic logic src_match(input logic [REG_W-1:0] r,
                                      input logic [REG_W-1:0] rs1,
                                      input logic [REG_W-1:0] rs2,
                                      input logic             use1,
                                      input logic             use2);
      return (r != '0) && ((use1 && (r == rs1)) || (use2 && (r == rs2)));
   endfunction

   logic ex_match;
   logic mem_match;

   // Compare EX and MEM destinations against the ID sources.
   always_comb begin
      ex_match  = src_match(ex_rd,  id_rs1, id_rs2, id_use_rs1, id_use_rs2);
      mem_match = src_match(mem_rd, id_rs1, id_rs2, id_use_rs1, id_use_rs2);
      luse      = ex_is_load & ex_wen & ex_match;
      bdep      = id_is_branch & ((ex_wen & ex_match) | (mem_is_load & mem_match));
   end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: resolves memory
// waits, redirects and data hazards into fetch and ID/EX control strobes,
// and keeps saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
   parameter int REG_W     = pipe_hazard_ctrl_pkg::REG_W,
   parameter int PERF_W    = 32,
   parameter int FLUSH_LAT = 1    // 1..3 extra nop cycles after a redirect
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              iready_n,
   input  logic              dready_n,
   input  logic [REG_W-1:0]  id_rs1,
   input  logic [REG_W-1:0]  id_rs2,
   input  logic              id_use_rs1,
   input  logic              id_use_rs2,
   input  logic              id_is_branch,
   input  logic [REG_W-1:0]  ex_rd,
   input  logic              ex_wen,
   input  logic              ex_is_load,
   input  logic [REG_W-1:0]  mem_rd,
   input  logic              mem_is_load,
   input  logic              br_early_taken,
   input  logic              br_ex_taken,
   output logic              keep,
   output logic              nop,
   output logic              br_early_sel,
   output logic              br_ex_sel,
   output logic              id_ex_bubble,
   output logic              pipe_freeze,
   output logic [PERF_W-1:0] stall_cnt,
   output logic [PERF_W-1:0] flush_cnt
);

   import pipe_hazard_ctrl_pkg::*;

   localparam logic [FCNT_W-1:0] FLUSH_INIT = FCNT_W'(FLUSH_LAT - 1);

   state_e             state_q, state_d;
   logic [FCNT_W-1:0]  fcnt_q, fcnt_d;
   logic [PERF_W-1:0]  stall_cnt_q, stall_cnt_d;
   logic [PERF_W-1:0]  flush_cnt_q, flush_cnt_d;
   logic               luse;
   logic               bdep;
   sel_e               sel;

   pipe_hazard_detect #(
      .REG_W (REG_W)
   ) u_detect (
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .id_is_branch (id_is_branch),
      .ex_rd        (ex_rd),
      .ex_wen       (ex_wen),
      .ex_is_load   (ex_is_load),
      .mem_rd       (mem_rd),
      .mem_is_load  (mem_is_load),
      .luse         (luse),
      .bdep         (bdep)
   );

   // Pick the single highest-priority condition that owns this cycle.
   always_comb begin
      sel = SEL_IDLE;
      if (dready_n)                sel = SEL_FREEZE;
      else if (br_ex_taken)        sel = SEL_EX_BR;
      else if (state_q == FLUSH)   sel = SEL_FLUSH;   // early branch is wrong-path here
      else if (luse || bdep)       sel = SEL_HAZARD;  // early branch waits for operands
      else if (br_early_taken)     sel = SEL_ID_BR;
      else if (iready_n)           sel = SEL_IWAIT;
   end

   // FSM state register; reset is synchronous and only acts on a clock edge.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of process ordering.
      if (!rst) begin
         state_q <= RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   // FSM next state: redirects (re)start the flush countdown, FLUSH counts down.
   always_comb begin
      // NOTE: defaults first so no path through the case leaves a value
      // unassigned, which would otherwise infer a latch.
      state_d = state_q;
      fcnt_d  = fcnt_q;
      unique case (sel)
         SEL_EX_BR, SEL_ID_BR: begin
            state_d = FLUSH;
            fcnt_d  = FLUSH_INIT;
         end
         SEL_FLUSH: begin
            if (fcnt_q == '0) state_d = RUN;
            else              fcnt_d  = fcnt_q - 1'b1;
         end
         default: ;  // freeze, hazard, ifetch wait and idle all hold the FSM
      endcase
   end

   // Outputs: decode the winning condition; everything forced low in reset.
   always_comb begin
      keep         = 1'b0;
      nop          = 1'b0;
      br_early_sel = 1'b0;
      br_ex_sel    = 1'b0;
      id_ex_bubble = 1'b0;
      pipe_freeze  = 1'b0;
      if (rst) begin
         unique case (sel)
            SEL_FREEZE: begin
               pipe_freeze = 1'b1;
               keep        = 1'b1;
            end
            SEL_EX_BR: begin
               br_ex_sel    = 1'b1;
               nop          = 1'b1;
               id_ex_bubble = 1'b1;
            end
            SEL_FLUSH: nop = 1'b1;
            SEL_HAZARD: begin
               keep         = 1'b1;
               id_ex_bubble = 1'b1;
            end
            SEL_ID_BR: begin
               br_early_sel = 1'b1;
               nop          = 1'b1;
            end
            SEL_IWAIT: begin
               keep = 1'b1;
               nop  = 1'b1;
            end
            default: ;
         endcase
      end
   end

   // Counter next values: +1 per qualifying cycle, sticking at all-ones.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if ((keep || pipe_freeze) && (stall_cnt_q != '1))
         stall_cnt_d = stall_cnt_q + PERF_W'(1);
      if ((br_ex_sel || br_early_sel) && (flush_cnt_q != '1))
         flush_cnt_d = flush_cnt_q + PERF_W'(1);
   end

   // Performance counter registers.
   always_ff @(posedge clk) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = rst ? stall_cnt_q : '0;
   assign flush_cnt = rst ? flush_cnt_q : '0;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl. Counters are built 4 bits wide so
// saturation is reachable in a handful of cycles.
module tb_pipe_hazard_ctrl;

   localparam int REG_W  = 5;
   localparam int PERF_W = 4;

   // Output vector order: {keep, nop, br_early_sel, br_ex_sel, id_ex_bubble, pipe_freeze}
   localparam logic [5:0] O_IDLE   = 6'b000000;
   localparam logic [5:0] O_HAZARD = 6'b100010;
   localparam logic [5:0] O_EX_BR  = 6'b010110;
   localparam logic [5:0] O_FLUSH  = 6'b010000;
   localparam logic [5:0] O_FREEZE = 6'b100001;
   localparam logic [5:0] O_ID_BR  = 6'b011000;
   localparam logic [5:0] O_IWAIT  = 6'b110000;

   logic              clk = 1'b0;
   logic              rst;
   logic              iready_n, dready_n;
   logic [REG_W-1:0]  id_rs1, id_rs2, ex_rd, mem_rd;
   logic              id_use_rs1, id_use_rs2, id_is_branch;
   logic              ex_wen, ex_is_load, mem_is_load;
   logic              br_early_taken, br_ex_taken;
   logic              keep, nop, br_early_sel, br_ex_sel, id_ex_bubble, pipe_freeze;
   logic [PERF_W-1:0] stall_cnt, flush_cnt;
   logic [5:0]        outs;

   int checks = 0;
   int errors = 0;

   pipe_hazard_ctrl #(
      .REG_W     (REG_W),
      .PERF_W    (PERF_W),
      .FLUSH_LAT (1)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .iready_n       (iready_n),
      .dready_n       (dready_n),
      .id_rs1         (id_rs1),
      .id_rs2         (id_rs2),
      .id_use_rs1     (id_use_rs1),
      .id_use_rs2     (id_use_rs2),
      .id_is_branch   (id_is_branch),
      .ex_rd          (ex_rd),
      .ex_wen         (ex_wen),
      .ex_is_load     (ex_is_load),
      .mem_rd         (mem_rd),
      .mem_is_load    (mem_is_load),
      .br_early_taken (br_early_taken),
      .br_ex_taken    (br_ex_taken),
      .keep           (keep),
      .nop            (nop),
      .br_early_sel   (br_early_sel),
      .br_ex_sel      (br_ex_sel),
      .id_ex_bubble   (id_ex_bubble),
      .pipe_freeze    (pipe_freeze),
      .stall_cnt      (stall_cnt),
      .flush_cnt      (flush_cnt)
   );

   always #5 clk = ~clk;

   assign outs = {keep, nop, br_early_sel, br_ex_sel, id_ex_bubble, pipe_freeze};

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Advance past the next rising edge; inputs change 1 time unit after it.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Let combinational outputs settle after an input change.
   task automatic settle();
      #1;
   endtask

   task automatic clear_inputs();
      iready_n       = 1'b0;
      dready_n       = 1'b0;
      id_rs1         = '0;
      id_rs2         = '0;
      id_use_rs1     = 1'b0;
      id_use_rs2     = 1'b0;
      id_is_branch   = 1'b0;
      ex_rd          = '0;
      ex_wen         = 1'b0;
      ex_is_load     = 1'b0;
      mem_rd         = '0;
      mem_is_load    = 1'b0;
      br_early_taken = 1'b0;
      br_ex_taken    = 1'b0;
   endtask

   initial begin
      // Reset held with aggressive inputs: every output must stay low.
      clear_inputs();
      rst         = 1'b0;
      br_ex_taken = 1'b1;
      dready_n    = 1'b1;
      iready_n    = 1'b1;
      settle();
      check("rst_outs_low", 32'(outs), 32'(O_IDLE));
      check("rst_stall_cnt", 32'(stall_cnt), 32'd0);
      tick();
      tick();
      check("rst_outs_low_after_edge", 32'(outs), 32'(O_IDLE));
      rst = 1'b1;
      clear_inputs();
      settle();
      check("run_idle", 32'(outs), 32'(O_IDLE));
      check("run_stall_cnt0", 32'(stall_cnt), 32'd0);
      check("run_flush_cnt0", 32'(flush_cnt), 32'd0);
      tick();

      // 1: load-use on rs1 stalls one cycle.
      ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b1;
      settle();
      check("luse_stall", 32'(outs), 32'(O_HAZARD));
      tick();                                             // stall_cnt 1
      ex_rd = 5'd0; id_rs1 = 5'd0;
      settle();
      check("luse_x0_no_stall", 32'(outs), 32'(O_IDLE));
      ex_rd = 5'd5; id_rs1 = 5'd5; id_use_rs1 = 1'b0;
      settle();
      check("luse_rs1_unused", 32'(outs), 32'(O_IDLE));
      ex_is_load = 1'b0; id_use_rs1 = 1'b1;
      settle();
      check("alu_dep_forwarded", 32'(outs), 32'(O_IDLE));
      check("stall_cnt_after_luse", 32'(stall_cnt), 32'd1);
      clear_inputs();
      tick();

      // 2: late branch pulse -> redirect cycle, one FLUSH nop, then idle.
      br_ex_taken = 1'b1;
      settle();
      check("exbr_cyc0", 32'(outs), 32'(O_EX_BR));
      tick();                                             // flush_cnt 1
      br_ex_taken = 1'b0;
      settle();
      check("exbr_cyc1_nop", 32'(outs), 32'(O_FLUSH));
      tick();
      settle();
      check("exbr_cyc2_idle", 32'(outs), 32'(O_IDLE));
      check("flush_cnt_1", 32'(flush_cnt), 32'd1);

      // 3: both redirects together -> late wins; early ignored during FLUSH.
      br_ex_taken = 1'b1; br_early_taken = 1'b1;
      settle();
      check("both_br_ex_wins", 32'(outs), 32'(O_EX_BR));
      tick();                                             // flush_cnt 2
      br_ex_taken = 1'b0;
      settle();
      check("flush_ignores_early", 32'(outs), 32'(O_FLUSH));
      tick();
      clear_inputs();
      settle();
      check("flush_cnt_2", 32'(flush_cnt), 32'd2);

      // 4: data-memory wait during FLUSH freezes, then the FLUSH nop resumes.
      br_ex_taken = 1'b1;
      tick();                                             // flush_cnt 3
      br_ex_taken = 1'b0;
      dready_n    = 1'b1;
      for (int i = 0; i < 3; i++) begin
         settle();
         check($sformatf("freeze_in_flush_%0d", i), 32'(outs), 32'(O_FREEZE));
         tick();
      end                                                 // stall_cnt 4
      dready_n = 1'b0;
      settle();
      check("flush_nop_after_freeze", 32'(outs), 32'(O_FLUSH));
      tick();
      settle();
      check("idle_after_freeze_flush", 32'(outs), 32'(O_IDLE));
      check("stall_cnt_4", 32'(stall_cnt), 32'd4);
      check("flush_cnt_3", 32'(flush_cnt), 32'd3);

      // 5: early branch blocked by MEM-load dependency on rs2, then taken.
      id_is_branch = 1'b1; mem_is_load = 1'b1; mem_rd = 5'd7;
      id_rs2 = 5'd7; id_use_rs2 = 1'b1; br_early_taken = 1'b1;
      settle();
      check("bdep_blocks_early", 32'(outs), 32'(O_HAZARD));
      tick();                                             // stall_cnt 5
      mem_rd = 5'd0;
      settle();
      check("early_taken", 32'(outs), 32'(O_ID_BR));
      tick();                                             // flush_cnt 4
      clear_inputs();
      settle();
      check("early_flush_nop", 32'(outs), 32'(O_FLUSH));
      tick();
      // Early branch on an EX ALU result also waits.
      id_is_branch = 1'b1; ex_wen = 1'b1; ex_rd = 5'd3; id_rs1 = 5'd3; id_use_rs1 = 1'b1;
      settle();
      check("bdep_ex_alu", 32'(outs), 32'(O_HAZARD));
      tick();                                             // stall_cnt 6
      clear_inputs();
      iready_n = 1'b1;
      settle();
      check("iwait", 32'(outs), 32'(O_IWAIT));
      tick();                                             // stall_cnt 7
      iready_n = 1'b0;
      dready_n = 1'b1; ex_is_load = 1'b1; ex_wen = 1'b1; ex_rd = 5'd9;
      id_rs1 = 5'd9; id_use_rs1 = 1'b1; br_early_taken = 1'b1;
      settle();
      check("freeze_beats_hazard", 32'(outs), 32'(O_FREEZE));
      tick();                                             // stall_cnt 8
      clear_inputs();
      settle();
      check("stall_cnt_8", 32'(stall_cnt), 32'd8);
      check("flush_cnt_4", 32'(flush_cnt), 32'd4);

      // 6: reset mid-FLUSH drops state and counters.
      br_ex_taken = 1'b1;
      tick();                                             // FLUSH, flush_cnt 5
      br_ex_taken = 1'b0;
      rst         = 1'b0;
      iready_n    = 1'b1;
      settle();
      check("rst_mid_flush_outs", 32'(outs), 32'(O_IDLE));
      tick();
      rst      = 1'b1;
      iready_n = 1'b0;
      settle();
      check("post_rst_run", 32'(outs), 32'(O_IDLE));
      check("post_rst_stall_cnt", 32'(stall_cnt), 32'd0);
      check("post_rst_flush_cnt", 32'(flush_cnt), 32'd0);

      // Saturation: 14 stall cycles reach max-1, three more stick at all-ones.
      iready_n = 1'b1;
      for (int i = 0; i < 14; i++) tick();
      settle();
      check("stall_cnt_max_m1", 32'(stall_cnt), 32'd14);
      for (int i = 0; i < 3; i++) tick();
      settle();
      check("stall_cnt_saturated", 32'(stall_cnt), 32'd15);
      iready_n = 1'b0;
      tick();
      settle();
      check("stall_cnt_holds_max", 32'(stall_cnt), 32'd15);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
